// File: rtl/arb8_32.sv
// arb8_32: round-robin arbiter driving the select of the shared 32-bit 8:1 mux.
// One requester owns the mux at a time. The consumer's valid/ready handshake is
// forwarded, and an owner is forced off after MAX_HOLD accepted beats whenever
// another requester is waiting. Handovers happen on the release edge itself,
// so the mux never sits idle between two owners.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid follows req[owner] combinationally while busy; the consumer may
// hold out_ready low for any number of cycles, and that never causes a release.
//
// The FSM state is visible on busy (busy == state is OWN).
module arb8_32 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] mux8_ctr,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [2:0] owner;
    logic [2:0] ptr;
    logic [7:0] beat_cnt;

    logic       owner_req;
    logic [7:0] others;
    logic       accept;
    logic [2:0] next_ptr;
    logic [2:0] handover_pick;
    logic [2:0] idle_pick;

    // First set bit of r, searching circularly upward from start.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] sel;
        logic [2:0] idx;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // The next owner always excludes the current one and is searched from
    // owner+1, which covers both voluntary and forced release.
    assign owner_req     = req[owner];
    assign others        = req & ~(8'h01 << owner);
    assign out_valid     = (state == OWN) && owner_req;
    assign accept        = out_valid && out_ready;
    assign next_ptr      = owner + 3'd1;
    assign handover_pick = pick(others, next_ptr);
    assign idle_pick     = pick(req, ptr);

    // Arbitration FSM with registered grant, select and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 3'd0;
            ptr      <= 3'd0;
            beat_cnt <= 8'd0;
            gnt      <= 8'h00;
            mux8_ctr <= 3'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= idle_pick;
                        mux8_ctr <= idle_pick;
                        gnt      <= 8'h01 << idle_pick;
                        beat_cnt <= 8'd0;
                        busy     <= 1'b1;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        // Voluntary release; no beat can be counted this edge.
                        ptr      <= next_ptr;
                        beat_cnt <= 8'd0;
                        if (|others) begin
                            owner    <= handover_pick;
                            mux8_ctr <= handover_pick;
                            gnt      <= 8'h01 << handover_pick;
                        end else begin
                            gnt   <= 8'h00;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        if (beat_cnt == LIMIT) begin
                            // Limit reached: hand over if anyone waits, else keep going.
                            beat_cnt <= 8'd0;
                            if (|others) begin
                                ptr      <= next_ptr;
                                owner    <= handover_pick;
                                mux8_ctr <= handover_pick;
                                gnt      <= 8'h01 << handover_pick;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_32.sv
// Testbench for arb8_32 with the default MAX_HOLD of 4.
module tb_arb8_32;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] mux8_ctr;
    logic       out_valid;
    logic       busy;

    int total;
    int bad;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] gnt;
        logic [2:0] mux;
        logic       busy;
        logic       valid;
    } vec_t;

    vec_t tbl[7];

    arb8_32 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .gnt       (gnt),
        .mux8_ctr  (mux8_ctr),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard compare
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] e;
        total = 0;
        bad   = 0;

        // single requester, then wrap of the start pointer
        tbl[0] = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1};
        tbl[1] = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1};
        tbl[2] = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1};
        tbl[3] = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[5] = '{8'h09, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        // reset values
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        #2;
        check("rst_gnt", gnt, 8'h00);
        check("rst_mux", 8'(mux8_ctr), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_valid", 8'(out_valid), 8'h00);

        // table vectors
        do_reset();
        for (int v = 0; v < 7; v++) begin
            req       = tbl[v].req;
            out_ready = tbl[v].rdy;
            step();
            check($sformatf("tbl%0d_gnt", v), gnt, tbl[v].gnt);
            check($sformatf("tbl%0d_mux", v), 8'(mux8_ctr), 8'(tbl[v].mux));
            check($sformatf("tbl%0d_busy", v), 8'(busy), 8'(tbl[v].busy));
            check($sformatf("tbl%0d_valid", v), 8'(out_valid), 8'(tbl[v].valid));
        end
        check("tbl_beats", dut.beat_cnt, 8'd0);

        // full contention: each owner leaves after one accepted beat
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(1 << i));
        req       = 8'hFF;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            check($sformatf("contend%0d_gnt", i), gnt, e);
            check($sformatf("contend%0d_mux", i), 8'(mux8_ctr), 8'(i));
            step();
            check($sformatf("contend%0d_hold", i), gnt, e);
            req[i] = 1'b0;
            step();
        end
        check("contend_end_gnt", gnt, 8'h00);
        check("contend_end_busy", 8'(busy), 8'h00);

        // fairness between requesters 0 and 5 at MAX_HOLD=4
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back((r % 2 == 0) ? 8'h01 : 8'h20);
        req       = 8'h21;
        out_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            step();
            e = exp_q.pop_front();
            check($sformatf("fair%0d_gnt", s), gnt, e);
        end

        // backpressure on owner 2, then forced handover to 3
        do_reset();
        req       = 8'h0C;
        out_ready = 1'b0;
        step();
        check("bp_grant", gnt, 8'h04);
        for (int s = 0; s < 20; s++) begin
            step();
            check($sformatf("bp%0d_gnt", s), gnt, 8'h04);
            check($sformatf("bp%0d_cnt", s), dut.beat_cnt, 8'd0);
        end
        out_ready = 1'b1;
        for (int a = 1; a < 4; a++) begin
            step();
            check($sformatf("bp_acc%0d_gnt", a), gnt, 8'h04);
            check($sformatf("bp_acc%0d_cnt", a), dut.beat_cnt, 8'(a));
        end
        step();
        check("bp_forced_gnt", gnt, 8'h08);
        check("bp_forced_mux", 8'(mux8_ctr), 8'd3);

        // asynchronous reset in the middle of owner 3
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", gnt, 8'h00);
        check("arst_busy", 8'(busy), 8'h00);
        check("arst_mux", 8'(mux8_ctr), 8'h00);
        check("arst_valid", 8'(out_valid), 8'h00);
        req       = 8'h08;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("arst_regrant_gnt", gnt, 8'h08);
        check("arst_regrant_busy", 8'(busy), 8'h01);

        // sole requester at the limit keeps ownership
        do_reset();
        req       = 8'h40;
        out_ready = 1'b1;
        step();
        check("sole_grant", gnt, 8'h40);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("sole%0d_gnt", k), gnt, 8'h40);
            check($sformatf("sole%0d_cnt", k), dut.beat_cnt, 8'((k + 1) % 4));
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb8_32.md
# arb8_32

Round-robin arbiter that shares the 32-bit 8:1 datapath mux between eight requesters. It grants one requester at a time and drives the mux select so the selected requester's word reaches the shared consumer. It forwards the consumer's valid/ready handshake and limits each ownership to a bounded number of accepted beats whenever other requesters are waiting. It sits between the eight source units and the select input of the 8:1 32-bit mux in the datapath.

## Interface

Parameters:
- MAX_HOLD, default 4: maximum accepted beats per ownership while another requester is pending. Legal range is 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 8: req[i] high means requester i wants or keeps ownership and has a valid word on mux input i.
- out_ready, input, 1: the consumer accepts the current word.
- gnt, output, 8: one-hot grant; all zeros when idle. Registered.
- mux8_ctr, output, 3: select for the 8:1 mux, equal to the current owner index. Registered.
- out_valid, output, 1: the muxed word is valid. Equals state==OWN && req[owner].
- busy, output, 1: high when state==OWN. Registered.

## Operation

Internal state:
- FSM with states IDLE and OWN.
- owner[2:0]: current owner index.
- ptr[2:0]: round-robin start point.
- beat_cnt[7:0]: accepted-beat counter.

Pick function: the first i with req[i]=1, searching circularly from ptr upward (7 wraps to 0).

IDLE:
- gnt=0.
- If req!=0: owner is set to pick(req) from ptr, gnt becomes the one-hot of owner, mux8_ctr=owner, beat_cnt=0, and the FSM goes to OWN.

OWN:
- A beat is accepted when out_valid && out_ready. On each accept, beat_cnt increments.
- Voluntary release: req[owner]==0 at the edge.
  - ptr is set to owner+1 (mod 8).
  - If any other req is high, the next owner is granted at the same edge, picked from the new ptr, with no idle cycle.
  - Otherwise the FSM goes to IDLE and gnt becomes 0.
- Forced release: a beat is accepted, beat_cnt==MAX_HOLD-1, and some req[j]=1 with j!=owner.
  - ptr is set to owner+1.
  - The new owner is picked from the requesters other than the old owner and granted at the same edge.
- Limit reached with no other requester: ownership continues and beat_cnt is reset to 0.
- Without an accept, beat_cnt holds. Backpressure never forces a release.

Other rules:
- mux8_ctr keeps the last owner while in IDLE.
- gnt always matches mux8_ctr when busy=1.
- Requests from inactive requesters have no effect on the current owner except through forced release.
- If req[owner] drops in the same cycle out_ready is high, no beat is counted, because out_valid is low.

## Timing

- Reset values:
  - gnt=8'h00, mux8_ctr=3'd0, busy=0, out_valid=0.
  - FSM=IDLE, ptr=0, owner=0, beat_cnt=0.
- Asserting rst_n low clears everything immediately, independent of clk, including in the middle of an ownership. After release the block arbitrates from ptr=0.
- Grant latency: req first sampled high at edge k gives gnt, mux8_ctr and busy valid after edge k (one cycle).
- out_valid is combinational from req and registered state. It can follow req[owner] within a cycle.
- Handover, whether voluntary with other requesters pending or forced, takes zero idle cycles: the new gnt is valid right after the release edge.
- Worst-case wait for a continuously requesting requester: 7 × MAX_HOLD accepted beats plus 7 handover edges.

## Test plan

- Reset: drive rst_n low mid-OWN with gnt=8'h08. Required: gnt=0, busy=0, mux8_ctr=0, out_valid=0 immediately without a clock edge. With req=8'h08 after release, gnt=8'h08 one cycle later.
- Single requester: req=8'h08, out_ready=1, held 3 cycles then dropped. Required: gnt=8'h08 and mux8_ctr=3 one cycle after req, 3 accepted beats, gnt=0 after the drop edge. Then req=8'h09 grants 0 (ptr=4 wraps to 0).
- Full contention: req=8'hFF from reset, each owner drops its req after one accepted beat. Required grant order 0,1,2,…,7 with back-to-back handovers and no idle cycle.
- MAX_HOLD=4 fairness: req[0] and req[5] held high continuously, out_ready=1. Required: owner 0 for 4 beats, owner 5 for 4 beats, then 0 again, repeating, with no gaps.
- Backpressure: owner 2, out_ready=0 for 20 cycles while req=8'h0C. Required: gnt stays 8'h04 and beat_cnt stays 0. After out_ready rises, the forced handover to 3 happens exactly after the 4th accept.
- Sole requester at the limit: req=8'h40 only, out_ready=1 for 10 cycles. Required: gnt stays 8'h40 throughout, beat_cnt wraps 3→0, and no release occurs.
